// File: rtl/window_framer.sv
// Raster-to-3x3 window framer: buffers two previous rows and emits one window
// per interior pixel over a valid/ready handshake with single-entry output buffering.
module window_framer #(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int PIX_BITS   = 24
) (
  input  logic                          clk,
  input  logic                          n_rst,
  input  logic                          frame_start,
  input  logic [PIX_BITS-1:0]           pixel_in,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [9*PIX_BITS-1:0]         pixelData,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
  output logic                          frame_done
);

  localparam int RB = $clog2(IMG_HEIGHT);
  localparam int CB = $clog2(IMG_WIDTH);
  localparam logic [RB-1:0] ROW_LAST = RB'(IMG_HEIGHT - 1);
  localparam logic [CB-1:0] COL_LAST = CB'(IMG_WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FILL   = 2'd1,
    STREAM = 2'd2,
    DRAIN  = 2'd3
  } state_t;

  state_t state_r, state_s;
  logic [RB-1:0] row_r;
  logic [CB-1:0] col_r;
  logic [PIX_BITS-1:0] lb0_r [IMG_WIDTH];
  logic [PIX_BITS-1:0] lb1_r [IMG_WIDTH];
  logic [PIX_BITS-1:0] top0_r, top1_r, mid0_r, mid1_r, bot0_r, bot1_r;
  logic [9*PIX_BITS-1:0] data_r;
  logic [RB-1:0] out_row_r;
  logic [CB-1:0] out_col_r;
  logic out_valid_r, frame_done_r;

  logic abort_s, accept_s, xfer_s, load_s, col_last_s, row_last_s;
  logic [PIX_BITS-1:0] lb0_rd_s, lb1_rd_s;

  // A frame_start outside IDLE restarts the frame and beats any same-cycle accept.
  assign abort_s    = frame_start && (state_r != IDLE);
  assign in_ready   = ((state_r == FILL) || (state_r == STREAM)) && (!out_valid_r || out_ready);
  assign accept_s   = in_valid && in_ready && !frame_start;
  assign xfer_s     = out_valid_r && out_ready;
  assign col_last_s = (col_r == COL_LAST);
  assign row_last_s = (row_r == ROW_LAST);
  assign load_s     = accept_s && (state_r == STREAM) && (col_r >= CB'(2));
  assign lb0_rd_s   = lb0_r[col_r];
  assign lb1_rd_s   = lb1_r[col_r];

  assign pixelData  = data_r;
  assign out_valid  = out_valid_r;
  assign out_row    = out_row_r;
  assign out_col    = out_col_r;
  assign frame_done = frame_done_r;

  // Next-state selection for the frame sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (frame_start) state_s = FILL;
        else             state_s = IDLE;
      end
      FILL: begin
        if (abort_s)                                             state_s = FILL;
        else if (accept_s && (row_r == RB'(1)) && col_last_s)    state_s = STREAM;
        else                                                     state_s = FILL;
      end
      STREAM: begin
        if (abort_s)                                   state_s = FILL;
        else if (accept_s && row_last_s && col_last_s) state_s = DRAIN;
        else                                           state_s = STREAM;
      end
      DRAIN: begin
        if (abort_s)     state_s = FILL;
        else if (xfer_s) state_s = IDLE;
        else             state_s = DRAIN;
      end
      default: state_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Raster position of the next pixel to be accepted.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      row_r <= '0;
      col_r <= '0;
    end else if (frame_start) begin
      row_r <= '0;
      col_r <= '0;
    end else if (accept_s) begin
      if (col_last_s) begin
        col_r <= '0;
        if (!row_last_s) row_r <= row_r + RB'(1);
      end else begin
        col_r <= col_r + CB'(1);
      end
    end
  end

  // Line buffers: lb1 carries the previous row, lb0 the one before it.
  always_ff @(posedge clk) begin
    if (accept_s) begin
      lb0_r[col_r] <= lb1_rd_s;
      lb1_r[col_r] <= pixel_in;
    end
  end

  // Column shift register holding columns c-2 and c-1 of the current three rows.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      top0_r <= '0; top1_r <= '0;
      mid0_r <= '0; mid1_r <= '0;
      bot0_r <= '0; bot1_r <= '0;
    end else if (accept_s) begin
      top0_r <= top1_r; top1_r <= lb0_rd_s;
      mid0_r <= mid1_r; mid1_r <= lb1_rd_s;
      bot0_r <= bot1_r; bot1_r <= pixel_in;
    end
  end

  // Output slot: a new window loads as the previous one leaves, so throughput is 1/cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      out_valid_r  <= 1'b0;
      data_r       <= '0;
      out_row_r    <= '0;
      out_col_r    <= '0;
      frame_done_r <= 1'b0;
    end else begin
      frame_done_r <= (state_r == DRAIN) && xfer_s && !frame_start;
      if (abort_s) begin
        out_valid_r <= 1'b0;
      end else if (load_s) begin
        out_valid_r <= 1'b1;
        data_r      <= {top0_r, top1_r, lb0_rd_s,
                        mid0_r, mid1_r, lb1_rd_s,
                        bot0_r, bot1_r, pixel_in};
        out_row_r   <= row_r - RB'(1);
        out_col_r   <= col_r - CB'(1);
      end else if (xfer_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_window_framer.sv
// Bench for window_framer: a 5x4 instance driven by directed and random traffic
// against an image-level reference model, plus a 3x3 instance with literal checks.
module tb_window_framer;

  localparam int W = 5;
  localparam int H = 4;
  localparam logic [215:0] FIRST_WIN = {24'h000000, 24'h000001, 24'h000002,
                                        24'h000100, 24'h000101, 24'h000102,
                                        24'h000200, 24'h000201, 24'h000202};

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic frame_start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [23:0] pixel_in = 24'h0;
  logic in_ready, out_valid, frame_done;
  logic [215:0] pixelData;
  logic [1:0] out_row;
  logic [2:0] out_col;

  logic b_fs = 1'b0, b_iv = 1'b0, b_or = 1'b0;
  logic [23:0] b_pix = 24'h0;
  logic b_ir, b_ov, b_done;
  logic [215:0] b_data;
  logic [1:0] b_row, b_col;

  window_framer #(.IMG_WIDTH(W), .IMG_HEIGHT(H), .PIX_BITS(24)) dut (
    .clk(clk), .n_rst(n_rst), .frame_start(frame_start), .pixel_in(pixel_in),
    .in_valid(in_valid), .in_ready(in_ready), .pixelData(pixelData),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_col(out_col), .frame_done(frame_done));

  window_framer #(.IMG_WIDTH(3), .IMG_HEIGHT(3), .PIX_BITS(24)) dut_b (
    .clk(clk), .n_rst(n_rst), .frame_start(b_fs), .pixel_in(b_pix),
    .in_valid(b_iv), .in_ready(b_ir), .pixelData(b_data),
    .out_valid(b_ov), .out_ready(b_or), .out_row(b_row),
    .out_col(b_col), .frame_done(b_done));

  always #5 clk = ~clk;

  int checks = 0, passes = 0;

  // Reference model: image of accepted pixels plus the expected output slot.
  bit busy = 1'b0;
  int idx = 0;
  bit m_valid = 1'b0, m_done = 1'b0;
  logic [215:0] m_win = '0;
  int m_row = 0, m_col = 0;
  logic [23:0] acc_pix [W*H];

  int pix_mode = 0, iv_mode = 0, or_mode = 0, hold_cnt = 0;
  int win_cnt = 0, done_cnt = 0, aa_bad = 0;
  bit first_seen = 1'b0;
  logic [215:0] first_win = '0;
  int first_row = 0, first_col = 0;

  task automatic chk(input string name, input logic [215:0] act, input logic [215:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  function automatic logic [23:0] gen(input int i);
    int r, c;
    r = i / W;
    c = i % W;
    case (pix_mode)
      0:       return {8'h00, 8'(r), 8'(c)};
      1:       return {8'hAA, 8'(r), 8'(c)};
      default: return 24'($urandom);
    endcase
  endfunction

  function automatic logic [215:0] win(input int r, input int c);
    logic [215:0] w;
    w = '0;
    for (int dr = -1; dr <= 1; dr++)
      for (int dc = -1; dc <= 1; dc++)
        w = {w[191:0], acc_pix[(r + dr) * W + c + dc]};
    return w;
  endfunction

  task automatic step(input bit fs);
    bit exp_ir, acc, xfer, drain;
    int r, c;
    @(negedge clk);
    frame_start = fs;
    case (iv_mode)
      0:       in_valid = 1'b1;
      1:       in_valid = ~in_valid;
      default: in_valid = 1'($urandom_range(0, 1));
    endcase
    case (or_mode)
      0: out_ready = 1'b1;
      3: begin
        if (hold_cnt > 0 && m_valid) begin out_ready = 1'b0; hold_cnt--; end
        else out_ready = 1'b1;
      end
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    pixel_in = gen(idx);
    #1;
    exp_ir = busy && (idx < W * H) && (!m_valid || out_ready);
    chk("in_ready", in_ready, exp_ir);
    acc  = in_valid && exp_ir && !fs;
    xfer = m_valid && out_ready;
    if (xfer) begin
      win_cnt++;
      if (!first_seen) begin
        first_seen = 1'b1;
        first_win  = pixelData;
        first_row  = out_row;
        first_col  = out_col;
      end
      if (pix_mode == 1)
        for (int k = 0; k < 9; k++)
          if (pixelData[k*24+16 +: 8] !== 8'hAA) aa_bad++;
    end
    @(posedge clk);
    #1;
    m_done = 1'b0;
    drain  = busy && (idx == W * H);
    if (fs && busy) begin
      idx = 0;
      m_valid = 1'b0;
    end else if (fs) begin
      busy = 1'b1;
      idx = 0;
    end else begin
      if (acc) begin
        r = idx / W;
        c = idx % W;
        acc_pix[idx] = pixel_in;
        idx++;
        if (r >= 2 && c >= 2) begin
          m_valid = 1'b1;
          m_win = win(r - 1, c - 1);
          m_row = r - 1;
          m_col = c - 1;
        end else if (xfer) m_valid = 1'b0;
      end else if (xfer) m_valid = 1'b0;
      if (drain && xfer) begin
        busy = 1'b0;
        m_done = 1'b1;
      end
    end
    chk("out_valid", out_valid, m_valid);
    chk("frame_done", frame_done, m_done);
    if (frame_done) done_cnt++;
    if (m_valid) begin
      chk("pixelData", pixelData, m_win);
      chk("out_row", out_row, m_row);
      chk("out_col", out_col, m_col);
    end
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pixelData", pixelData, 0);
    chk("rst_out_row", out_row, 0);
    chk("rst_out_col", out_col, 0);
    chk("rst_frame_done", frame_done, 0);
    busy = 1'b0; idx = 0; m_valid = 1'b0; m_done = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic run_frame(input int abort_at, input int rst_at);
    int cyc;
    bit aborted;
    win_cnt = 0; done_cnt = 0; first_seen = 1'b0; aa_bad = 0; aborted = 1'b0; hold_cnt = 4;
    step(1'b1);
    cyc = 0;
    while (busy && cyc < 3000) begin
      if (rst_at > 0 && idx == rst_at) begin
        do_reset();
        return;
      end
      if (abort_at > 0 && !aborted && idx == abort_at) begin
        pix_mode = 1;
        step(1'b1);
        aborted = 1'b1;
        win_cnt = 0;
        aa_bad = 0;
      end else begin
        step(1'b0);
      end
      cyc++;
    end
    chk("frame_timeout", busy, 0);
    step(1'b0);
    chk("window_count", win_cnt, (W - 2) * (H - 2));
    chk("done_count", done_cnt, 1);
  endtask

  initial begin
    #2;
    chk("init_in_ready", in_ready, 0);
    chk("init_out_valid", out_valid, 0);
    chk("init_pixelData", pixelData, 0);
    chk("init_frame_done", frame_done, 0);
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;

    // Streaming frame, in_valid and out_ready held high.
    pix_mode = 0; iv_mode = 0; or_mode = 0;
    run_frame(0, 0);
    chk("t1_first_win", first_win, FIRST_WIN);
    chk("t1_first_row", first_row, 1);
    chk("t1_first_col", first_col, 1);

    // Downstream stalls on the first window for four cycles.
    or_mode = 3;
    run_frame(0, 0);
    chk("t2_first_win", first_win, FIRST_WIN);

    // in_valid toggling every cycle.
    or_mode = 0; iv_mode = 1;
    run_frame(0, 0);
    chk("t3_first_win", first_win, FIRST_WIN);

    // Abort after 12 pixels, then a full AA-tagged frame.
    iv_mode = 0; pix_mode = 0;
    run_frame(12, 0);
    chk("t4_aa_bytes", aa_bad, 0);

    // Asynchronous reset mid-stream; pixels ignored until frame_start.
    pix_mode = 0;
    run_frame(0, 12);
    for (int i = 0; i < 5; i++) step(1'b0);
    run_frame(0, 0);
    chk("t5_first_win", first_win, FIRST_WIN);

    // Random pixels, valid and ready.
    pix_mode = 2; iv_mode = 2; or_mode = 2;
    for (int f = 0; f < 4; f++) run_frame(0, 0);

    // Minimum 3x3 frame on the second instance.
    @(negedge clk);
    b_fs = 1'b1;
    @(negedge clk);
    b_fs = 1'b0; b_iv = 1'b1; b_or = 1'b1;
    for (int k = 0; k < 9; k++) begin
      b_pix = {8'h00, 8'(k / 3), 8'(k % 3)};
      #1;
      chk("b_in_ready", b_ir, 1);
      @(negedge clk);
    end
    b_iv = 1'b0;
    for (int t = 0; t < 20; t++) begin
      if (b_ov) break;
      @(negedge clk);
    end
    chk("b_out_valid", b_ov, 1);
    chk("b_pixelData", b_data, FIRST_WIN);
    chk("b_out_row", b_row, 1);
    chk("b_out_col", b_col, 1);
    @(posedge clk);
    #1;
    chk("b_frame_done", b_done, 1);
    chk("b_out_valid_clr", b_ov, 0);
    @(posedge clk);
    #1;
    chk("b_frame_done_pulse", b_done, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/window_framer.md
Name: window_framer

Overview:
- Producer side of the 216-bit pixelData window interface consumed by intensity/edgedetect.
- Accepts a raster stream of 24bpp pixels: rows in file order, row 0 first; within a row, column 0 first.
- Buffers the two previous rows in line buffers and emits one 3x3 window per interior pixel, with a valid/ready handshake.
- Replaces bench-side frame assembly so a streamed image can drive the filter chain directly.

Parameters:
IMG_WIDTH, 640, pixels per row (>=3)
IMG_HEIGHT, 480, rows per frame (>=3)
PIX_BITS, 24, bits per pixel, byte order {R,G,B} with B in LSB

Ports:
clk  in  1  system clock
n_rst  in  1  asynchronous active-low reset
frame_start  in  1  one-cycle pulse; next accepted pixel is (row 0, col 0)
pixel_in  in  PIX_BITS  incoming pixel
in_valid  in  1  pixel_in valid
in_ready  out  1  block can accept pixel this cycle
pixelData  out  9*PIX_BITS  3x3 window, packed as described in Behaviour
out_valid  out  1  pixelData valid
out_ready  in  1  downstream accepts window
out_row  out  $clog2(IMG_HEIGHT)  row of window centre
out_col  out  $clog2(IMG_WIDTH)  column of window centre
frame_done  out  1  one-cycle pulse after last window of frame is accepted

Behaviour:
- Reset values: in_ready=0, out_valid=0, pixelData=0, out_row=0, out_col=0, frame_done=0. Line buffers are not reset.
- A pixel is accepted when in_valid && in_ready. A window is transferred when out_valid && out_ready.
- in_ready = (state==FILL || state==STREAM) && (!out_valid || out_ready). This is combinational and gives single-entry output buffering.
- States:
  - IDLE: frame_start -> FILL.
  - FILL: rows 0..1 accepted; no windows. The accept of (1, W-1) -> STREAM.
  - STREAM: each accept of (r, c) with r>=2 and c>=2 loads a window centred at (r-1, c-1). Accept of (H-1, W-1) -> DRAIN.
  - DRAIN: when the final window transfers, pulse frame_done and go to IDLE.
- frame_start in any state other than IDLE:
  - Abort: clear out_valid and the counters, go to FILL. Line buffer contents become stale and are overwritten.
  - This takes priority over a same-cycle pixel accept; that pixel is dropped.
- Counters: col wraps W-1 -> 0 and increments row; row stops at H-1. Counters advance only on accept.
- Line buffers:
  - Two W-deep arrays: lb1 holds row r-1, lb0 holds row r-2, indexed by col.
  - On accept at col c: lb0[c] <= lb1[c]; lb1[c] <= pixel_in.
  - The 3x3 shift register shifts left on every accept, loading the column {lb0[c], lb1[c], pixel_in}.
- Window packing, MSB to LSB, 24 bits each: {(r-1,c-1), (r-1,c), (r-1,c+1), (r,c-1), (r,c), (r,c+1), (r+1,c-1), (r+1,c), (r+1,c+1)} for centre (r, c).
  - Top-left occupies [215:192]; bottom-right occupies [23:0].
  - "r-1" means the earlier-received row.
- Windows never straddle a row boundary. Columns 0..1 of each row only prime the shift register.
- Latency: out_valid rises the cycle after accepting pixel (r+1, c+1). pixelData, out_row and out_col update on that same edge.
- Backpressure: while out_valid && !out_ready, pixelData, out_row and out_col hold stable and no pixel is accepted.
- Throughput: 1 window/cycle in steady state.
- Border pixels (row 0, row H-1, col 0, col W-1) produce no window; downstream passes them through.
- Window count per frame = (W-2)*(H-2).
- Reset mid-frame: all state returns to reset values immediately (asynchronous); frame_start is required before new data.

Test Plan:
1. W=5, H=4, pixel(r,c)=24'h00_rr_cc, stream with in_valid held high -> 6 windows, centres (1,1),(1,2),(1,3),(2,1),(2,2),(2,3) in order. First pixelData = {0000_00,0000_01,0000_02,0001_00,0001_01,0001_02,0002_00,0002_01,0002_02}. frame_done pulses once, one cycle after the 6th transfer.
2. Same image, out_ready held low for 4 cycles when the first window appears -> pixelData stable, in_ready=0 for all 4 cycles, no pixel lost, remaining 5 windows identical to case 1.
3. in_valid toggling 1/0 every cycle -> same 6 windows and contents as case 1; out_valid never asserted on a cycle without a preceding accept.
4. frame_start pulsed after 12 pixels, then a full frame with pixel=24'hAA_rr_cc -> out_valid cleared on the next edge, exactly 6 windows, all bytes bit[23:16]=AA (no stale data).
5. n_rst asserted during STREAM -> all outputs 0 asynchronously, in_ready=0. Pixels ignored until frame_start, then case 1 repeats exactly.
6. W=3, H=3 -> exactly one window centred (1,1) containing all 9 pixels in raster order; frame_done follows.
